max_pool_drain: RTL and testbench
=================================

Name: max_pool_drain

Overview:
- Write-side counterpart of the max-pool fill address generator.
- Accepts pooled output words from the max-pool stage over a valid/ready stream.
- Issues one memory write per word into the output feature-map buffer, starting at a base address and stepping in row-major order with a configurable row pitch.
- Pulses `done` when the full OUT_ROWS x OUT_COLS tile has been written.

Parameters:
- `add_size`, 20: width of all address signals.
- `DATA_W`, 16: width of one pooled result word.
- `OUT_ROWS`, 13: number of pooled output rows per tile (>=1).
- `OUT_COLS`, 13: number of pooled output columns per tile (>=1).
- `ROW_PITCH`, 13: address distance between the first words of consecutive output rows. Must be >= OUT_COLS; this is not checked in RTL.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a tile; sampled only in IDLE.
- `add_in` in add_size: tile base address, latched on an accepted `start`.
- `in_data` in DATA_W: pooled result word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word this cycle.
- `mem_we` out 1: write strobe, one cycle per word.
- `mem_addr` out add_size: write address.
- `mem_wdata` out DATA_W: write data.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse at the end of a tile.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; `in_ready`, `mem_we`, `busy` and `done` = 0; `mem_addr`, `mem_wdata`, `row`, `col` and `row_base` = 0.
  - Reset mid-tile abandons the tile.
  - No write is issued after reset asserts.
  - The block needs a fresh `start` once reset deasserts.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - `start`=1 -> RUN. Latch `row_base`=`add_in`, `row`=0, `col`=0.
  - `in_ready` goes high in the first RUN cycle.
  - `start` is ignored in RUN and DONE.
- RUN:
  - `in_ready`=1.
  - Accept when `in_valid` && `in_ready`. The cycle after an accept: `mem_we`=1, `mem_addr`=`row_base`+`col`, `mem_wdata`=the accepted `in_data`. Write latency is 1 cycle.
  - No accept -> `mem_we`=0 next cycle; `mem_addr` and `mem_wdata` hold their last values.
  - Index update on accept:
    - `col` < OUT_COLS-1: `col`++.
    - Otherwise: `col`=0, `row`++, `row_base` += ROW_PITCH.
  - On the accept with `row`==OUT_ROWS-1 and `col`==OUT_COLS-1:
    - next state = DONE;
    - `in_ready` drops next cycle, so no accept is possible after the final word.
- DONE (exactly one cycle):
  - The final `mem_we` and `done`=1 are asserted together.
  - -> IDLE.
  - `busy` falls in the following cycle.
- Arithmetic:
  - Address sums are modulo 2^add_size, i.e. wrap silently.
  - `row` and `col` counters are sized clog2 of their limit (minimum width 1).
- Back-to-back tiles: `start` in the first IDLE cycle after DONE is accepted. Minimum tile period is OUT_ROWS*OUT_COLS+2 cycles.
- `in_valid` while IDLE or DONE: no accept, no write, data dropped by the producer's rules (`in_ready`=0).
- Throughput: one word per cycle with `in_valid` held high; gaps in `in_valid` stall without losing position.

Test Plan (`OUT_ROWS`=2, `OUT_COLS`=3, `ROW_PITCH`=4 unless noted):
1. Reset, then `start` with `add_in`=20'h00010, then 6 words 1..6 with `in_valid` held high -> writes to 0x10, 0x11, 0x12, 0x14, 0x15, 0x16 with data 1..6 on consecutive cycles; `done`=1 coincident with the 0x16 write; `in_ready`=0 afterwards.
2. Same tile with `in_valid` toggled 1,0,1,0 -> same six addresses and data in order; `mem_we` is low in the gap cycles.
3. `add_in`=20'hFFFFE -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00002, 0x00003, 0x00004 (wrap-around).
4. Assert `reset` after the 4th accept -> all outputs 0 immediately; no 5th write; `start` with base 0x20 then runs a full clean tile from 0x20.
5. `start` pulsed mid-tile and `in_valid` asserted in IDLE -> both ignored; address sequence unchanged; no writes issued outside RUN/DONE.
6. Back-to-back: `start` the cycle after `done` with base 0x40 -> second tile writes 0x40..0x46 pattern; `done` pulses exactly twice in total.

Source files
------------

// File: rtl/max_pool_drain.sv
// Write-side address generator for pooled output tiles: accepts words over a
// valid/ready stream and writes them row-major from a base address with a row pitch.
module max_pool_drain #(
    parameter int add_size  = 20,
    parameter int DATA_W    = 16,
    parameter int OUT_ROWS  = 13,
    parameter int OUT_COLS  = 13,
    parameter int ROW_PITCH = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [add_size-1:0] add_in,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_we,
    output logic [add_size-1:0] mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done
);

    localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(OUT_ROWS - 1);
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(OUT_COLS - 1);
    localparam logic [add_size-1:0] PITCH    = add_size'(ROW_PITCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [ROW_W-1:0]    row, row_next;
    logic [COL_W-1:0]    col, col_next;
    logic [add_size-1:0] row_base, row_base_next;
    logic                in_ready_next, mem_we_next, busy_next, done_next;
    logic [add_size-1:0] mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_next;
    logic                accept, last_col, last_word;

    assign accept    = (state == RUN) && in_valid && in_ready;
    assign last_col  = (col == COL_LAST);
    assign last_word = last_col && (row == ROW_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            row       <= row_next;
            col       <= col_next;
            row_base  <= row_base_next;
            in_ready  <= in_ready_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        row_next       = row;
        col_next       = col;
        row_base_next  = row_base;
        in_ready_next  = in_ready;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        busy_next      = busy;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    row_base_next = add_in;
                    row_next      = '0;
                    col_next      = '0;
                    in_ready_next = 1'b1;
                    busy_next     = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = row_base + add_size'(col);
                    mem_wdata_next = in_data;
                    if (last_col) begin
                        col_next      = '0;
                        row_next      = row + 1'b1;
                        row_base_next = row_base + PITCH;
                    end else begin
                        col_next = col + 1'b1;
                    end
                    // Final word: drop ready now so nothing can be accepted in DONE.
                    if (last_word) begin
                        state_next    = DONE;
                        in_ready_next = 1'b0;
                        done_next     = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next    = IDLE;
                in_ready_next = 1'b0;
                busy_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_max_pool_drain.sv
// Randomized and directed bench for max_pool_drain; a word-count based reference
// model predicts every output each cycle.
module tb_max_pool_drain;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int PITCH = 4;
    localparam int N     = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] add_in = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    max_pool_drain #(
        .add_size(AW), .DATA_W(DW), .OUT_ROWS(ROWS), .OUT_COLS(COLS), .ROW_PITCH(PITCH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .add_in(add_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int cycle = 0;

    // Reference model: tracks words accepted in the current tile.
    logic          m_ready, m_we, m_busy, m_done;
    logic [AW-1:0] m_addr, m_base;
    logic [DW-1:0] m_wdata;
    int            m_n;
    logic [DW-1:0] words [N];

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int k);
        return AW'(int'(base) + (k / COLS) * PITCH + (k % COLS));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_we = 0; m_busy = 0; m_done = 0;
        m_addr = '0; m_wdata = '0; m_base = '0; m_n = 0;
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
        logic acc, old_busy, old_done;
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        acc = m_ready && v;
        old_busy = m_busy;
        old_done = m_done;
        m_we = acc;
        if (acc) begin
            m_addr  = addr_of(m_base, m_n);
            m_wdata = d;
            m_n++;
        end
        m_done = acc && (m_n == N);
        if (s && !old_busy) begin
            m_ready = 1; m_base = add_in; m_n = 0;
        end else if (m_done) begin
            m_ready = 0;
        end
        m_busy = (old_busy && !old_done) || (s && !old_busy);
        @(negedge clk);
        cycle++;
        if (done) done_seen++;
        check_all();
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) step(1'b0, v, DW'($urandom));
    endtask

    // mode 0: valid held, 1: toggled, 2: random. Stops early after abort_after words (0 = never).
    task automatic run_tile(input logic [AW-1:0] base, input int mode, input bit rnd_data,
                            input bit start_noise, input int abort_after);
        int t;
        logic v;
        for (int k = 0; k < N; k++) words[k] = rnd_data ? DW'($urandom) : DW'(k + 1);
        add_in = base;
        step(1'b1, 1'b0, '0);
        t = 0;
        while (m_busy && t < 100) begin
            if (abort_after != 0 && m_n == abort_after) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = 1'(($urandom % 3) != 0);
            endcase
            add_in = AW'($urandom);
            step(start_noise && (t == 1 || t == 4), v, words[m_n < N ? m_n : 0]);
            t++;
        end
        chk("tile_bound", 32'(t < 100), 32'(1));
    endtask

    initial begin
        int c0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        idle(2, 1'b0);

        // 1: streaming tile
        run_tile(20'h00010, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        // 2: gapped valid
        run_tile(20'h00010, 1, 1'b0, 1'b0, 0);
        idle(1, 1'b0);
        // 3: address wrap
        run_tile(20'hFFFFE, 0, 1'b1, 1'b0, 0);
        idle(1, 1'b0);

        // 4: reset after the fourth accept
        run_tile(20'h00030, 0, 1'b0, 1'b0, 4);
        chk("pre_reset_n", 32'(m_n), 32'(4));
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        idle(3, 1'b1);
        run_tile(20'h00020, 0, 1'b1, 1'b0, 0);

        // 5: start noise mid-tile, valid in idle
        idle(3, 1'b1);
        run_tile(20'h00050, 2, 1'b1, 1'b1, 0);
        idle(2, 1'b1);

        // 6: back-to-back tiles
        done_seen = 0;
        c0 = cycle;
        run_tile(20'h00040, 0, 1'b1, 1'b0, 0);
        chk("tile_period", 32'(cycle - c0), 32'(N + 2));
        run_tile(20'h00040, 0, 1'b1, 1'b0, 0);
        chk("done_count", 32'(done_seen), 32'(2));

        // random tiles
        for (int r = 0; r < 6; r++) begin
            run_tile(AW'($urandom), 2, 1'b1, 1'(r % 2), 0);
            idle(int'($urandom_range(0, 2)), 1'(r % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
